fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end that replaces the datapath's

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC, issues cache read requests, and buffers returned words
// together with their PCs in a small circular FIFO that decode drains through
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetch.
module fetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       ihit,
    input  logic [31:0]                imemload,
    output logic                       imemREN,
    output logic [31:0]                imemaddr,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       halt,
    input  logic                       inst_ready,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic [31:0]                inst_npc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Control state
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;

    // FIFO storage; contents are meaningless while count_q says the slot is free,
    // so the storage carries no reset.
    logic [31:0] mem_word [DEPTH];
    logic [31:0] mem_pc   [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A redirect suppresses both FIFO operations: the flush takes the edge.
    assign push = imemREN & ihit;
    assign pop  = !empty & inst_ready & !redirect;

    // Fetch/halt state register
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the cache request strobe
    always_comb begin
        state_next = state;
        imemREN    = 1'b0;
        if (state == RUN) begin
            if (halt) begin
                state_next = HALTED;
            end
            if (!halt && !redirect && !full) begin
                imemREN = 1'b1;
            end
        end
    end

    // Fetch PC: advances on each accepted word, reloads on redirect
    always_ff @(posedge CLK) begin
        if (nRST) begin
            fetch_pc <= PC_INIT;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (nRST || redirect) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage write: word and its PC land together at the tail
    always_ff @(posedge CLK) begin
        if (push && !nRST) begin
            mem_word[tail] <= imemload;
            mem_pc[tail]   <= fetch_pc;
        end
    end

    assign imemaddr   = fetch_pc;
    assign count      = count_q;
    assign inst_valid = !empty;

    // Head presentation; all-zero when nothing is buffered
    always_comb begin
        inst     = 32'h0;
        inst_pc  = 32'h0;
        inst_npc = 32'h0;
        if (!empty) begin
            inst     = mem_word[head];
            inst_pc  = mem_pc[head];
            inst_npc = mem_pc[head] + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-computed vector table plus a queue scoreboard
// of fetched {pc, word} pairs checked as decode pops them.
module tb_fetch_queue;

    localparam logic [31:0] PC_INIT = 32'h0000_0040;
    localparam int          DEPTH   = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'h0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_npc;
    logic [$clog2(DEPTH):0] count;

    fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .inst_ready(inst_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_npc(inst_npc), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    typedef struct {
        logic        ih;
        logic        rd;
        logic [31:0] rpc;
        logic        hl;
        logic        rdy;
        logic        ren;   // expected imemREN before the edge
        logic [31:0] cnt;   // expected count after the edge
        logic        vld;   // expected inst_valid after the edge
        logic [31:0] addr;  // expected imemaddr after the edge
        logic [31:0] hpc;   // expected inst_pc after the edge
    } vec_t;

    ent_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] m_pc;
    bit          m_halted;
    logic        pre_ren;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ih, input logic rd, input logic [31:0] rpc,
                       input logic hl, input logic rdy, input logic ren,
                       input logic [31:0] cnt, input logic vld,
                       input logic [31:0] addr, input logic [31:0] hpc);
        vec_t v;
        v.ih = ih; v.rd = rd; v.rpc = rpc; v.hl = hl; v.rdy = rdy;
        v.ren = ren; v.cnt = cnt; v.vld = vld; v.addr = addr; v.hpc = hpc;
        tbl.push_back(v);
    endtask

    // One clock: drive inputs, check against the scoreboard model, update it.
    task automatic step(input logic ih, input logic rd, input logic [31:0] rpc,
                        input logic hl, input logic rdy);
        bit   m_ren;
        bit   m_push;
        bit   m_pop;
        ent_t e;
        @(negedge CLK);
        ihit = ih; redirect = rd; redirect_pc = rpc; halt = hl; inst_ready = rdy;
        imemload = word_of(m_pc);
        m_ren  = !m_halted && !hl && !rd && (sb.size() < DEPTH);
        m_push = m_ren && ih;
        m_pop  = (sb.size() != 0) && rdy && !rd;
        #1;
        pre_ren = imemREN;
        chk("imemREN", 32'(imemREN), 32'(m_ren));
        chk("imemaddr", imemaddr, m_pc);
        chk("count", 32'(count), 32'(sb.size()));
        chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_inst", inst, sb[0].word);
            chk("head_pc", inst_pc, sb[0].pc);
            chk("head_npc", inst_npc, sb[0].pc + 32'd4);
        end else begin
            chk("empty_inst", inst, 32'h0);
            chk("empty_pc", inst_pc, 32'h0);
            chk("empty_npc", inst_npc, 32'h0);
        end
        if (rd) begin
            sb.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (m_pop) e = sb.pop_front();
            if (m_push) begin
                e.pc = m_pc;
                e.word = word_of(m_pc);
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (hl) m_halted = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Reset with busy inputs asserted; reset must win over all of them.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b1; ihit = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0888;
        halt = 1'b1; inst_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; halt = 1'b0; inst_ready = 1'b0;
        #1;
        chk("rst_imemREN", 32'(imemREN), 32'h1);
        chk("rst_imemaddr", imemaddr, PC_INIT);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_npc", inst_npc, 32'h0);
        sb.delete();
        m_pc = PC_INIT;
        m_halted = 1'b0;
    endtask

    initial begin
        // ih rd rpc hl rdy | ren cnt vld addr hpc
        add(1, 0, 32'h0,   0, 0,  1, 1, 1, 32'h44,  32'h40);   // T1 fill
        add(1, 0, 32'h0,   0, 0,  1, 2, 1, 32'h48,  32'h40);
        add(1, 0, 32'h0,   0, 0,  1, 3, 1, 32'h4C,  32'h40);
        add(1, 0, 32'h0,   0, 0,  1, 4, 1, 32'h50,  32'h40);
        add(1, 0, 32'h0,   0, 0,  0, 4, 1, 32'h50,  32'h40);   // full: ihit ignored
        add(1, 0, 32'h0,   0, 1,  0, 3, 1, 32'h50,  32'h44);   // T2 pop from full
        add(1, 0, 32'h0,   0, 0,  1, 4, 1, 32'h54,  32'h44);   // refetch 0x50
        add(0, 0, 32'h0,   0, 1,  0, 3, 1, 32'h54,  32'h48);
        add(1, 1, 32'h203, 0, 1,  0, 0, 0, 32'h200, 32'h0);    // T3 redirect
        add(1, 0, 32'h0,   0, 1,  1, 1, 1, 32'h204, 32'h200);  // T4 streaming
        add(1, 0, 32'h0,   0, 1,  1, 1, 1, 32'h208, 32'h204);
        add(1, 0, 32'h0,   0, 1,  1, 1, 1, 32'h20C, 32'h208);
        add(1, 0, 32'h0,   0, 1,  1, 1, 1, 32'h210, 32'h20C);
        add(1, 0, 32'h0,   0, 0,  1, 2, 1, 32'h214, 32'h20C);  // T5 count=2
        add(1, 0, 32'h0,   1, 0,  0, 2, 1, 32'h214, 32'h20C);  // halt pulse
        add(1, 0, 32'h0,   0, 1,  0, 1, 1, 32'h214, 32'h210);  // drain
        add(1, 0, 32'h0,   0, 1,  0, 0, 0, 32'h214, 32'h0);
        add(1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h214, 32'h0);
        add(1, 1, 32'h300, 0, 0,  0, 0, 0, 32'h300, 32'h0);    // halted redirect
        add(1, 0, 32'h0,   0, 0,  0, 0, 0, 32'h300, 32'h0);

        m_pc = PC_INIT;
        m_halted = 1'b0;
        pre_ren = 1'b0;
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].ih, tbl[i].rd, tbl[i].rpc, tbl[i].hl, tbl[i].rdy);
            chk($sformatf("v%0d_ren", i), 32'(pre_ren), 32'(tbl[i].ren));
            chk($sformatf("v%0d_count", i), 32'(count), tbl[i].cnt);
            chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_addr", i), imemaddr, tbl[i].addr);
            chk($sformatf("v%0d_headpc", i), inst_pc, tbl[i].hpc);
        end

        // Halted is left only by reset
        do_reset();

        // T6: address wrap at the top of memory
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("t6_addr_top", imemaddr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t6_addr_wrap", imemaddr, 32'h0);
        chk("t6_head_pc", inst_pc, 32'hFFFF_FFFC);
        chk("t6_head_npc", inst_npc, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset while full and mid-redirect
        repeat (DEPTH + 1) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'(DEPTH));
        do_reset();

        // Random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                 $urandom, 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < DEPTH + 1; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("final_empty", 32'(inst_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
